// File: rtl/wptr_full_sync.sv
// Write-side pointer and flag controller for the dual-clock FIFO: binary/Gray write
// pointers, read-pointer synchroniser, registered full/almost-full/count/overflow.
module wptr_full_sync #(
  parameter int unsigned ADDR_WD     = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               wclk,
  input  logic               wrst_n,
  input  logic               winc,
  input  logic [ADDR_WD:0]   rptr_gray,
  input  logic [ADDR_WD:0]   afull_thresh,
  input  logic               wovf_clr,
  output logic               wen,
  output logic [ADDR_WD-1:0] waddr,
  output logic [ADDR_WD:0]   wptr,
  output logic               wfull,
  output logic               walmost_full,
  output logic [ADDR_WD:0]   wcount,
  output logic               woverflow
);

  logic [ADDR_WD:0] r_sync [SYNC_STAGES];
  logic [ADDR_WD:0] r_wbin;
  logic [ADDR_WD:0] r_wgray;
  logic [ADDR_WD:0] r_wcount;
  logic             r_wfull;
  logic             r_walmost_full;
  logic             r_woverflow;

  logic [ADDR_WD:0] w_rq_gray;
  logic [ADDR_WD:0] w_rq_bin;
  logic [ADDR_WD:0] w_wbnext;
  logic [ADDR_WD:0] w_wgnext;
  logic [ADDR_WD:0] w_cnext;
  logic [ADDR_WD:0] w_full_match;
  logic             w_wen;
  logic             w_ovf_set;

  always_comb w_rq_gray = r_sync[SYNC_STAGES-1];

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    w_rq_bin = '0;
    for (int unsigned i = 0; i <= ADDR_WD; i++) begin
      w_rq_bin[i] = ^(w_rq_gray >> i);
    end
  end

  always_comb begin
    w_wen        = winc & ~r_wfull;
    w_wbnext     = r_wbin + {{ADDR_WD{1'b0}}, w_wen};
    w_wgnext     = (w_wbnext >> 1) ^ w_wbnext;
    // Full when the next write pointer is one lap ahead of the synchronised read pointer.
    w_full_match = {~w_rq_gray[ADDR_WD:ADDR_WD-1], w_rq_gray[ADDR_WD-2:0]};
    w_cnext      = w_wbnext - w_rq_bin;
    w_ovf_set    = winc & r_wfull;
  end

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= '0;
      end
      r_wbin         <= '0;
      r_wgray        <= '0;
      r_wcount       <= '0;
      r_wfull        <= 1'b0;
      r_walmost_full <= 1'b0;
      r_woverflow    <= 1'b0;
    end else begin
      r_sync[0] <= rptr_gray;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_wbin         <= w_wbnext;
      r_wgray        <= w_wgnext;
      r_wcount       <= w_cnext;
      r_wfull        <= (w_wgnext == w_full_match);
      r_walmost_full <= (w_cnext >= afull_thresh);
      if (w_ovf_set) begin
        r_woverflow <= 1'b1;
      end else if (wovf_clr) begin
        r_woverflow <= 1'b0;
      end
    end
  end

  always_comb begin
    wen          = w_wen;
    waddr        = r_wbin[ADDR_WD-1:0];
    wptr         = r_wgray;
    wfull        = r_wfull;
    walmost_full = r_walmost_full;
    wcount       = r_wcount;
    woverflow    = r_woverflow;
  end

endmodule

// File: tb/tb_wptr_full_sync.sv
// Self-checking bench for wptr_full_sync: reference model feeds an expected-value
// queue per clock, plus directed checks for the fill/overflow/drain/wrap scenarios.
module tb_wptr_full_sync;

  localparam int unsigned AW = 4;
  localparam int unsigned SS = 2;

  logic          wclk = 1'b0;
  logic          wrst_n = 1'b0;
  logic          winc = 1'b0;
  logic [AW:0]   rptr_gray = '0;
  logic [AW:0]   afull_thresh = '0;
  logic          wovf_clr = 1'b0;
  logic          wen;
  logic [AW-1:0] waddr;
  logic [AW:0]   wptr;
  logic          wfull;
  logic          walmost_full;
  logic [AW:0]   wcount;
  logic          woverflow;

  wptr_full_sync #(.ADDR_WD(AW), .SYNC_STAGES(SS)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .winc(winc), .rptr_gray(rptr_gray),
    .afull_thresh(afull_thresh), .wovf_clr(wovf_clr), .wen(wen), .waddr(waddr),
    .wptr(wptr), .wfull(wfull), .walmost_full(walmost_full), .wcount(wcount),
    .woverflow(woverflow)
  );

  always #5 wclk = ~wclk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [AW-1:0] waddr;
    logic [AW:0]   wptr;
    logic          full;
    logic          afull;
    logic [AW:0]   cnt;
    logic          ovf;
  } exp_t;

  exp_t sb[$];

  // Reference model state
  logic [AW:0] m_wbin = '0, m_s0 = '0, m_s1 = '0, m_cnt = '0;
  logic        m_full = 1'b0, m_afull = 1'b0, m_ovf = 1'b0, m_known = 1'b0;

  function automatic logic [AW:0] gray(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [AW:0] g2b(input logic [AW:0] g);
    logic [AW:0] b;
    b = g;
    for (int s = 1; s <= int'(AW); s++) b = b ^ (g >> s);
    return b;
  endfunction

  task automatic model_edge(input logic rst_n_i, input logic winc_i, input logic clr_i,
                            input logic [AW:0] rptr_i, input logic [AW:0] thr_i);
    logic [AW:0] bnext, gnext, cnext;
    logic        wen_m;
    exp_t        e;
    if (!rst_n_i) begin
      m_wbin = '0; m_s0 = '0; m_s1 = '0; m_cnt = '0;
      m_full = 1'b0; m_afull = 1'b0; m_ovf = 1'b0; m_known = 1'b1;
    end else begin
      wen_m = winc_i & ~m_full;
      bnext = m_wbin + {{AW{1'b0}}, wen_m};
      gnext = gray(bnext);
      cnext = bnext - g2b(m_s1);
      if (winc_i && m_full) m_ovf = 1'b1;
      else if (clr_i)       m_ovf = 1'b0;
      m_full  = (gnext == {~m_s1[AW:AW-1], m_s1[AW-2:0]});
      m_afull = (cnext >= thr_i);
      m_cnt   = cnext;
      m_wbin  = bnext;
      m_s1    = m_s0;
      m_s0    = rptr_i;
    end
    e.waddr = m_wbin[AW-1:0];
    e.wptr  = gray(m_wbin);
    e.full  = m_full;
    e.afull = m_afull;
    e.cnt   = m_cnt;
    e.ovf   = m_ovf;
    sb.push_back(e);
  endtask

  // Drive one cycle of stimulus, check wen before the edge, then pop and compare after it.
  task automatic step(input logic rst_n_i, input logic winc_i, input logic clr_i,
                      input logic [AW:0] rptr_i, input logic [AW:0] thr_i);
    exp_t e;
    wrst_n = rst_n_i; winc = winc_i; wovf_clr = clr_i;
    rptr_gray = rptr_i; afull_thresh = thr_i;
    #1;
    if (m_known) check_eq("wen", {31'b0, wen}, {31'b0, winc_i & ~m_full});
    model_edge(rst_n_i, winc_i, clr_i, rptr_i, thr_i);
    @(posedge wclk);
    #1;
    if (sb.size() == 0) begin
      check_eq("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check_eq("waddr", {28'b0, waddr}, {28'b0, e.waddr});
      check_eq("wptr", {27'b0, wptr}, {27'b0, e.wptr});
      check_eq("wfull", {31'b0, wfull}, {31'b0, e.full});
      check_eq("walmost_full", {31'b0, walmost_full}, {31'b0, e.afull});
      check_eq("wcount", {27'b0, wcount}, {27'b0, e.cnt});
      check_eq("woverflow", {31'b0, woverflow}, {31'b0, e.ovf});
    end
  endtask

  logic [AW:0] prev_ptr;
  logic [AW:0] jb;

  initial begin
    @(posedge wclk);
    #1;
    // Reset held with write request and a non-zero read pointer
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 5'b00101, 5'd12);
      check_eq("rst_wptr", {27'b0, wptr}, 32'd0);
      check_eq("rst_wcount", {27'b0, wcount}, 32'd0);
      check_eq("rst_wfull", {31'b0, wfull}, 32'd0);
    end
    // Read pointer 00101 (binary 6) lands in the flags on the third edge after release
    for (int i = 1; i <= 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 5'b00101, 5'd12);
      check_eq("sync_lat_wcount", {27'b0, wcount}, (i == 3) ? 32'd26 : 32'd0);
    end

    // Fill 16 words
    step(1'b0, 1'b0, 1'b0, 5'b00000, 5'd12);
    for (int i = 1; i <= 16; i++) begin
      winc = 1'b1;
      #1;
      check_eq("fill_waddr", {28'b0, waddr}, 32'(i - 1));
      step(1'b1, 1'b1, 1'b0, 5'b00000, 5'd12);
      check_eq("fill_afull", {31'b0, walmost_full}, (i >= 12) ? 32'd1 : 32'd0);
      check_eq("fill_full", {31'b0, wfull}, (i == 16) ? 32'd1 : 32'd0);
    end
    check_eq("full_wptr", {27'b0, wptr}, 32'b11000);
    check_eq("full_wcount", {27'b0, wcount}, 32'd16);

    // Overflow set, hold with simultaneous clear, then clear
    step(1'b1, 1'b1, 1'b0, 5'b00000, 5'd12);
    check_eq("ovf_set", {31'b0, woverflow}, 32'd1);
    check_eq("ovf_wptr_held", {27'b0, wptr}, 32'b11000);
    step(1'b1, 1'b1, 1'b1, 5'b00000, 5'd12);
    check_eq("ovf_set_wins", {31'b0, woverflow}, 32'd1);
    step(1'b1, 1'b0, 1'b1, 5'b00000, 5'd12);
    check_eq("ovf_clr", {31'b0, woverflow}, 32'd0);

    // Drain: read pointer moves to 4 then 5; flags follow three edges later
    for (int i = 1; i <= 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 5'b00110, 5'd12);
      check_eq("drain4_full", {31'b0, wfull}, (i == 3) ? 32'd0 : 32'd1);
      check_eq("drain4_wcount", {27'b0, wcount}, (i == 3) ? 32'd12 : 32'd16);
      check_eq("drain4_afull", {31'b0, walmost_full}, 32'd1);
    end
    for (int i = 1; i <= 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 5'b00111, 5'd12);
      check_eq("drain5_wcount", {27'b0, wcount}, (i == 3) ? 32'd11 : 32'd12);
      check_eq("drain5_afull", {31'b0, walmost_full}, (i == 3) ? 32'd0 : 32'd1);
    end

    // Wrap-around with a trailing read pointer, threshold 0 keeps almost-full set
    step(1'b0, 1'b0, 1'b0, 5'b00000, 5'd0);
    prev_ptr = '0;
    for (int j = 1; j <= 40; j++) begin
      jb = (j > 3) ? 5'(j - 3) : 5'd0;
      step(1'b1, 1'b1, 1'b0, gray(jb), 5'd0);
      check_eq("wrap_wptr", {27'b0, wptr}, {27'b0, gray(5'(j))});
      check_eq("wrap_1bit", $countones(wptr ^ prev_ptr), 32'd1);
      check_eq("wrap_nofull", {31'b0, wfull}, 32'd0);
      check_eq("wrap_cnt_le5", {31'b0, (wcount <= 5'd5)}, 32'd1);
      check_eq("wrap_afull", {31'b0, walmost_full}, 32'd1);
      prev_ptr = wptr;
    end

    // Mid-operation reset while full and overflowed; threshold above depth never fires
    step(1'b0, 1'b0, 1'b0, 5'b00000, 5'd17);
    for (int i = 0; i < 17; i++) step(1'b1, 1'b1, 1'b0, 5'b00000, 5'd17);
    check_eq("mid_ovf", {31'b0, woverflow}, 32'd1);
    check_eq("mid_afull_never", {31'b0, walmost_full}, 32'd0);
    step(1'b1, 1'b0, 1'b0, 5'b00110, 5'd17);
    step(1'b1, 1'b0, 1'b0, 5'b00110, 5'd17);
    step(1'b0, 1'b1, 1'b0, 5'b00000, 5'd17);
    check_eq("mid_rst_wptr", {27'b0, wptr}, 32'd0);
    check_eq("mid_rst_full", {31'b0, wfull}, 32'd0);
    check_eq("mid_rst_ovf", {31'b0, woverflow}, 32'd0);
    step(1'b1, 1'b0, 1'b0, 5'b00000, 5'd17);
    check_eq("mid_sync_cleared", {27'b0, wcount}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
